// File: rtl/lzs_encode_pack.sv
// LZS token packer: serialises literal/match/end tokens into MSB-first 16-bit words.
// Latency: a token's first field lands in the accumulator on its accept edge; a word is visible the cycle after 16 bits are pending.
// Backpressure: out_ready low stops pops; once 16+ bits are pending, appends and tok_ready stall until the next pop.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start          one-cycle pulse, begins a stream from IDLE
//   tok_valid/rdy  token handshake; tok_type 00 lit, 01 match, 10/11 end
//   tok_lit/off/len literal byte, match offset (1..2047), match length (2..4095)
//   out_data/valid/ready  packed word handshake, first stream bit at out_data[15]
//   done           one-cycle pulse after the final padded word is accepted
module lzs_encode_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic [1:0]  tok_type,
    input  logic [7:0]  tok_lit,
    input  logic [10:0] tok_off,
    input  logic [11:0] tok_len,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOK,
        S_LEN,
        S_EXT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] acc, acc_n, acc_pop;
    logic [5:0]  cnt, cnt_n, cnt_pop;
    logic [11:0] len_q, len_n;
    logic [11:0] ext_q, ext_n;

    logic        pop;
    logic        append_ok;
    logic        app;
    logic        flush_round;
    logic [12:0] fld;
    logic [3:0]  fw;
    logic [5:0]  sh;

    assign out_valid = (cnt >= 6'd16);
    assign out_data  = acc[31:16];
    assign done      = (state == S_DONE);

    assign pop       = out_valid && out_ready;
    assign acc_pop   = pop ? {acc[15:0], 16'h0000} : acc;
    assign cnt_pop   = pop ? (cnt - 6'd16) : cnt;
    // cnt <= 31 always, so an append after a pop starts at bit <= 15 and a
    // 13-bit field still fits inside the accumulator.
    assign append_ok = (cnt < 6'd16) || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= 32'h0;
            cnt   <= 6'd0;
            len_q <= 12'd0;
            ext_q <= 12'd0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            len_q <= len_n;
            ext_q <= ext_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len_q;
        ext_n       = ext_q;
        tok_ready   = 1'b0;
        app         = 1'b0;
        flush_round = 1'b0;
        fld         = 13'h0;
        fw          = 4'd0;

        case (state)
            S_IDLE: begin
                if (start) state_n = S_TOK;
            end
            S_TOK: begin
                tok_ready = append_ok;
                if (tok_valid && append_ok) begin
                    app = 1'b1;
                    case (tok_type)
                        2'b00: begin
                            fld = {4'b0000, 1'b0, tok_lit};
                            fw  = 4'd9;
                        end
                        2'b01: begin
                            len_n   = tok_len;
                            state_n = S_LEN;
                            if (tok_off < 11'd128) begin
                                fld = {4'b0000, 2'b11, tok_off[6:0]};
                                fw  = 4'd9;
                            end else begin
                                fld = {2'b10, tok_off};
                                fw  = 4'd13;
                            end
                        end
                        default: begin
                            // End marker; reserved type is treated the same.
                            fld     = {4'b0000, 9'b110000000};
                            fw      = 4'd9;
                            state_n = S_FLUSH;
                        end
                    endcase
                end
            end
            S_LEN: begin
                if (append_ok) begin
                    app = 1'b1;
                    if (len_q <= 12'd4) begin
                        // 2,3,4 -> 00,01,10
                        fld     = {11'h0, len_q[1:0] - 2'd2};
                        fw      = 4'd2;
                        state_n = S_TOK;
                    end else if (len_q <= 12'd7) begin
                        // 5,6,7 -> 1100,1101,1110
                        fld     = {9'h0, 2'b11, len_q[1:0] - 2'd1};
                        fw      = 4'd4;
                        state_n = S_TOK;
                    end else begin
                        fld     = 13'h000F;
                        fw      = 4'd4;
                        ext_n   = len_q - 12'd8;
                        state_n = S_EXT;
                    end
                end
            end
            S_EXT: begin
                if (append_ok) begin
                    app = 1'b1;
                    fw  = 4'd4;
                    if (ext_q >= 12'd15) begin
                        fld   = 13'h000F;
                        ext_n = ext_q - 12'd15;
                    end else begin
                        fld     = {9'h0, ext_q[3:0]};
                        state_n = S_TOK;
                    end
                end
            end
            S_FLUSH: begin
                // Bits below cnt are always zero, so rounding cnt up to a
                // word boundary is all the padding needed.
                if (cnt_pop == 6'd0) begin
                    state_n = S_DONE;
                end else if (cnt_pop <= 6'd16) begin
                    flush_round = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Left-justify the field just below the bits that survive the pop.
        sh    = 6'd32 - {2'b00, fw} - cnt_pop;
        acc_n = acc_pop;
        cnt_n = cnt_pop;
        if (app) begin
            acc_n = acc_pop | ({19'h0, fld} << sh);
            cnt_n = cnt_pop + {2'b00, fw};
        end
        if (flush_round) begin
            cnt_n = 6'd16;
        end
    end

endmodule
